// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Latches the execute bus, selects ALU result or load data, and keeps the
// one-cycle SRAM read word in a buffer while write-back stalls.
// Optional feature macro: MS_FWD_EN (drives the bypass bus to decode;
// when undefined the bypass bus is tied to zero).
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 38
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  logic                       ms_valid;
  logic                       ms_first;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic [31:0]                rdata_buf;
  logic                       rdata_buf_valid;

  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_result;
  logic [31:0] final_result;
  logic        accept;
  logic        capture;
  logic        leave;

  assign {res_from_mem, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign leave          = ms_valid && ws_allowin;
  // The SRAM word is only valid in the first cycle, so grab it only if we
  // cannot hand off in that same cycle.
  assign capture        = ms_valid && ms_first && res_from_mem && !ws_allowin;

  assign mem_result   = rdata_buf_valid ? rdata_buf : data_sram_rdata;
  assign final_result = res_from_mem ? mem_result : alu_result;
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MS_FWD_EN
  assign ms_to_ds_bus = {ms_valid && gr_we, dest, final_result};
`else
  assign ms_to_ds_bus = '0;
`endif

  // Pipeline register: valid bit, latched bus and first-cycle marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      ms_first       <= 1'b0;
      es_to_ms_bus_r <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (accept) begin
        es_to_ms_bus_r <= es_to_ms_bus;
      end
      ms_first <= accept;
    end
  end

  // One-entry load-data buffer; cleared when the instruction leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf       <= '0;
      rdata_buf_valid <= 1'b0;
    end else if (leave) begin
      rdata_buf_valid <= 1'b0;
    end else if (capture) begin
      rdata_buf       <= data_sram_rdata;
      rdata_buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected hand-offs are queued
// when the execute stage's instruction is accepted and compared while the
// instruction sits in the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [31:0] data_sram_rdata;
  logic [37:0] ms_to_ds_bus;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ds_bus    (ms_to_ds_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [69:0] ws;
    logic [37:0] ds;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  int   checks   = 0;
  int   failures = 0;
  int   handoffs = 0;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic rfm, input logic we, input logic [4:0] dest,
                              input logic [31:0] alu, input logic [31:0] pc,
                              input logic [31:0] rdata);
    exp_t e;
    logic [31:0] fr;
    fr   = rfm ? rdata : alu;
    e.ws = {we, dest, fr, pc};
`ifdef MS_FWD_EN
    e.ds = {we, dest, fr};
`else
    e.ds = '0;
`endif
    return e;
  endfunction

  // Present an instruction; rdata is the word the bench will return for it.
  task automatic drive(input logic rfm, input logic we, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] rdata);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = {rfm, we, dest, alu, pc};
    nxt            = mk(rfm, we, dest, alu, pc, rdata);
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = {$urandom, $urandom, $urandom};
  endtask

  // One clock: check outputs at the falling edge, update the model, step.
  task automatic cycle(input string tag);
    logic mv;
    exp_t e;
    @(negedge clk);
    mv = (q.size() != 0);
    chk({tag, " valid"}, ms_to_ws_valid, mv);
    chk({tag, " allowin"}, ms_allowin, !mv || ws_allowin);
    if (mv) begin
      e = q[0];
      chk({tag, " ws_bus"}, ms_to_ws_bus, e.ws);
      chk({tag, " ds_bus"}, ms_to_ds_bus, e.ds);
    end
    if (reset) begin
      q.delete();
    end else begin
      if (mv && ws_allowin) begin
        void'(q.pop_front());
        handoffs++;
      end
      if (es_to_ms_valid && (!mv || ws_allowin)) q.push_back(nxt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h0;
    reset           = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    data_sram_rdata = '0;
    nxt             = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst allowin", ms_allowin, 1'b1);
    chk("rst valid", ms_to_ws_valid, 1'b0);
    chk("rst ds_bus", ms_to_ds_bus, 38'b0);
    chk("rst ws_bus", ms_to_ws_bus, 70'b0);
    @(posedge clk);
    #1;

    // ALU pass-through
    drive(1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h1C00_0010, 32'h0);
    cycle("alu_acc");
    idle();
    data_sram_rdata = 32'h5A5A_5A5A;
    cycle("alu_out");
    cycle("alu_gone");

    // Load, no stall
    drive(1'b1, 1'b1, 5'd7, 32'h0000_0040, 32'h1C00_0014, 32'hDEAD_BEEF);
    cycle("ld_acc");
    idle();
    data_sram_rdata = 32'hDEAD_BEEF;
    cycle("ld_out");
    data_sram_rdata = 32'h0BAD_0BAD;
    cycle("ld_gone");

    // Bubble with write-back stalled still accepts; then load stalled 3 cycles
    ws_allowin = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 32'h0000_0044, 32'h1C00_0018, 32'hDEAD_BEEF);
    cycle("st_acc");
    idle();
    data_sram_rdata = 32'hDEAD_BEEF;
    cycle("st_n1");
    data_sram_rdata = 32'h1111_1111;
    cycle("st_n2");
    cycle("st_n3");
    ws_allowin = 1'b1;
    cycle("st_n4");
    cycle("st_gone");

    // Reset during a load stall
    drive(1'b1, 1'b1, 5'd4, 32'h0000_0048, 32'h1C00_001C, 32'hAAAA_5555);
    cycle("rm_acc");
    idle();
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'hAAAA_5555;
    cycle("rm_n1");
    data_sram_rdata = 32'h0;
    cycle("rm_n2");
    reset = 1'b1;
    cycle("rm_rst");
    reset      = 1'b0;
    ws_allowin = 1'b1;
    cycle("rm_after");
    drive(1'b1, 1'b1, 5'd6, 32'h0000_004C, 32'h1C00_0020, 32'h2222_2222);
    cycle("rm_ld_acc");
    idle();
    data_sram_rdata = 32'h2222_2222;
    cycle("rm_ld_out");
    cycle("rm_ld_gone");

    // Back-to-back alternating load / ALU stream
    h0 = handoffs;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        drive((i % 2) == 0, (i % 3) != 0, 5'(i + 10), 32'hA100_0000 + i,
              32'h1C00_0100 + 4 * i, 32'hC0DE_0000 + i);
      end else begin
        idle();
      end
      if (i > 0 && ((i - 1) % 2) == 0) data_sram_rdata = 32'hC0DE_0000 + (i - 1);
      else data_sram_rdata = $urandom;
      cycle("stream");
    end
    chk("stream handoffs", 70'(handoffs - h0), 70'd10);
    cycle("end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
